onewire_master: RTL and testbench
=================================

# onewire_master

Byte-level 1-Wire bus master that generates reset/presence, write-byte and read-byte sequences on an open-drain one-wire line. It feeds the `onewire` line buffer: `W_OUT` drives the buffer input, and `W_IN` is the buffered bus level read back. Platform workers use it to read serial-ID/EEPROM devices. All slot timing derives from one clock via a microsecond prescaler.

## Interface

Parameters:
- `CLK_PER_US`, default 100: clock cycles per microsecond. Legal range 4..1023.

Ports:
- `CLK`, in, 1: the single clock.
- `RST`, in, 1: reset, asynchronous, active-high.
- `CMD_VALID`, in, 1: command request.
- `CMD_READY`, out, 1: high only in IDLE; a command is accepted when `CMD_VALID` and `CMD_READY` are both high on a rising edge.
- `CMD_OP`, in, 2: operation code. 00 = bus reset/presence; 01 = write byte; 10 = read byte; 11 = no-op.
- `CMD_DATA`, in, 8: byte to write; captured on accept.
- `RSP_VALID`, out, 1: one-cycle completion pulse. There is no backpressure.
- `RSP_DATA`, out, 8: byte read. Holds its value until the next read completes.
- `RSP_PRESENCE`, out, 1: presence result of the last reset op. Holds its value until the next reset op completes.
- `BUSY`, out, 1: equals the inverse of `CMD_READY`.
- `W_OUT`, out, 1: bus drive. 0 pulls the line low; 1 releases it. Registered.
- `W_IN`, in, 1: sensed bus level. Asynchronous; passed through a 2-flop synchronizer before use.

## Operation

- States: IDLE, RST_LOW, RST_REL, SLOT_LOW, SLOT_REL, DONE.
- Timebase:
  - The prescaler counts 0..CLK_PER_US-1 and emits `us_tick` at CLK_PER_US-1.
  - A 9-bit microsecond counter `us` increments on `us_tick`.
  - Both prescaler and `us` clear on command accept and on every phase change.
- Reset op (00):
  - RST_LOW: `W_OUT`=0 for 480 µs.
  - RST_REL: `W_OUT`=1 for 480 µs.
  - At `us`=70 in RST_REL, the synchronized `W_IN` is sampled. Presence = 1 if the sample is 0.
- Write byte (01):
  - 8 slots, LSB first; bit index runs 0..7.
  - Bit 1: SLOT_LOW 6 µs, then SLOT_REL 64 µs.
  - Bit 0: SLOT_LOW 60 µs, then SLOT_REL 10 µs.
- Read byte (10):
  - 8 slots, each SLOT_LOW 6 µs then SLOT_REL 64 µs.
  - The synchronized `W_IN` is sampled at `us`=9 of SLOT_REL (15 µs from slot start).
  - Each sample shifts into bit [index] of a shift register, LSB first.
- After bit 7 (or after RST_REL ends), go to DONE:
  - DONE lasts one cycle and pulses `RSP_VALID`.
  - `RSP_DATA` (read op) or `RSP_PRESENCE` (reset op) updates in the same cycle.
  - Then return to IDLE.
- No-op (11): accepted, goes directly to DONE, pulses `RSP_VALID`. `RSP_DATA` and `RSP_PRESENCE` are unchanged.
- `CMD_VALID` asserted while busy is ignored and not queued.
- Reset, any time (including mid-slot or while the line is held low):
  - `W_OUT`=1 immediately (asynchronous), state → IDLE.
  - `RSP_VALID`=0, `RSP_DATA`=0, `RSP_PRESENCE`=0; counters and synchronizer cleared.
  - The aborted op produces no `RSP_VALID`.
- Reset values: `W_OUT`=1, `CMD_READY`=1, `BUSY`=0, `RSP_VALID`=0, `RSP_DATA`=8'h00, `RSP_PRESENCE`=0.

## Timing

- Accept at edge N:
  - `W_OUT` changes on edge N+1 for reset, write and read ops.
  - `CMD_READY` falls on edge N+1.
- Phase length T µs equals exactly T·CLK_PER_US cycles of `W_OUT` held at that level.
- Total duration from first drive edge to `RSP_VALID`:
  - Reset op: 960·CLK_PER_US cycles.
  - Write or read op: 560·CLK_PER_US cycles.
- `RSP_VALID` is high the cycle after the last phase cycle. `CMD_READY` returns the cycle after `RSP_VALID`.
- Back-to-back: a command presented with `CMD_VALID` held high is accepted on the first IDLE cycle.
- No-op latency: `RSP_VALID` at edge N+1, `CMD_READY` high again at edge N+2.
- Sample skew: the synchronizer adds 2 cycles. The sample point is defined at the synchronizer output, so the effective bus sample is 2 cycles earlier.

## Test plan

- Reset with presence, `CLK_PER_US`=4:
  - Stimulus: model pulls `W_IN` low from 30–150 µs after release.
  - Required: `W_OUT` low for exactly 1920 cycles, then high for 1920 cycles; `RSP_VALID` pulse; `RSP_PRESENCE`=1.
  - Repeat with no device: `RSP_PRESENCE`=0.
- Write 8'hA5:
  - Required low-pulse widths, in order, in cycles: 24, 240, 24, 240, 240, 24, 240, 24.
  - Slot period 280 cycles; `RSP_VALID` at 2240 cycles after the first drive edge.
- Read with a model returning 8'h3C:
  - Model holds `W_IN` low for 0-bits until 30 µs after slot start.
  - Required: `RSP_DATA`=8'h3C; 8 low pulses of 24 cycles each.
- Reset mid-write:
  - Stimulus: assert `RST` while `W_OUT`=0 in bit 3.
  - Required: `W_OUT`=1 in the same cycle (asynchronous), no `RSP_VALID`, `CMD_READY`=1 after release; a following read completes normally.
- Handshake:
  - `CMD_VALID` held high with ops 11, 01 (8'h00), 11.
  - Required: no-op `RSP_VALID` at accept+1; the write is accepted 2 cycles after the first accept; the second no-op is accepted 1 cycle after the write's `RSP_VALID`.
  - A command pulsed while busy is never executed.
  - `RSP_DATA` and `RSP_PRESENCE` are unchanged by no-ops and writes.

Source files
------------

// File: rtl/onewire_master.sv
// onewire_master: byte-level 1-Wire bus master.
// Runs bus reset/presence, write-byte and read-byte sequences on an open-drain line.
// All slot timing is derived from CLK through a microsecond prescaler.
//
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   CMD_VALID/READY command handshake (READY high only while idle)
//   CMD_OP          00 reset/presence, 01 write byte, 10 read byte, 11 no-op
//   CMD_DATA        byte to write, captured on accept
//   RSP_VALID       one-cycle completion pulse
//   RSP_DATA        last byte read (held)
//   RSP_PRESENCE    presence result of last reset op (held)
//   BUSY            inverse of CMD_READY
//   W_OUT           registered bus drive, 0 pulls low, 1 releases
//   W_IN            sensed bus level, asynchronous
module onewire_master #(
  parameter int unsigned CLK_PER_US = 100
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic [7:0] CMD_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       RSP_PRESENCE,
  output logic       BUSY,
  output logic       W_OUT,
  input  logic       W_IN
);

  localparam int unsigned     PreW   = $clog2(CLK_PER_US);
  localparam logic [PreW-1:0] PreMax = PreW'(CLK_PER_US - 1);

  localparam logic [1:0] OpReset = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StRstLow, StRstRel, StSlotLow, StSlotRel, StDone
  } state_e;

  state_e          state_q;
  logic [PreW-1:0] pre_q;
  logic [8:0]      us_q;
  logic [1:0]      sync_q;
  logic [1:0]      op_q;
  logic [7:0]      data_q;
  logic [2:0]      bit_q;
  logic [7:0]      rd_q;
  logic            pres_q;
  logic            w_out_q;
  logic            ready_q;
  logic            rsp_valid_q;
  logic [7:0]      rsp_data_q;
  logic            rsp_pres_q;

  logic       us_tick;
  logic       w_sync;
  logic       slot_one;
  logic       phase_end;
  logic [8:0] phase_len;

  assign us_tick = (pre_q == PreMax);
  assign w_sync  = sync_q[1];
  // Read slots use the same short-low timing as a written 1.
  assign slot_one = (op_q != OpWrite) || data_q[bit_q];

  always_comb begin
    phase_len = 9'd1;
    case (state_q)
      StRstLow, StRstRel: phase_len = 9'd480;
      StSlotLow:          phase_len = slot_one ? 9'd6 : 9'd60;
      StSlotRel:          phase_len = slot_one ? 9'd64 : 9'd10;
      default:            phase_len = 9'd1;
    endcase
  end

  // Last cycle of the current phase.
  assign phase_end = us_tick && (us_q == phase_len - 9'd1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      pre_q       <= '0;
      us_q        <= '0;
      sync_q      <= '0;
      op_q        <= '0;
      data_q      <= '0;
      bit_q       <= '0;
      rd_q        <= '0;
      pres_q      <= 1'b0;
      w_out_q     <= 1'b1;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_pres_q  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], W_IN};
      rsp_valid_q <= 1'b0;
      if (us_tick) begin
        pre_q <= '0;
        us_q  <= us_q + 9'd1;
      end else begin
        pre_q <= pre_q + PreW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (CMD_VALID) begin
            op_q    <= CMD_OP;
            data_q  <= CMD_DATA;
            bit_q   <= '0;
            pre_q   <= '0;
            us_q    <= '0;
            ready_q <= 1'b0;
            case (CMD_OP)
              OpReset: begin
                state_q <= StRstLow;
                w_out_q <= 1'b0;
              end
              OpWrite, OpRead: begin
                state_q <= StSlotLow;
                w_out_q <= 1'b0;
              end
              default: begin
                state_q     <= StDone;
                rsp_valid_q <= 1'b1;
              end
            endcase
          end
        end
        StRstLow: begin
          if (phase_end) begin
            state_q <= StRstRel;
            w_out_q <= 1'b1;
            pre_q   <= '0;
            us_q    <= '0;
          end
        end
        StRstRel: begin
          if (us_q == 9'd70 && pre_q == '0) pres_q <= ~w_sync;
          if (phase_end) begin
            state_q     <= StDone;
            rsp_valid_q <= 1'b1;
            rsp_pres_q  <= pres_q;
            pre_q       <= '0;
            us_q        <= '0;
          end
        end
        StSlotLow: begin
          if (phase_end) begin
            state_q <= StSlotRel;
            w_out_q <= 1'b1;
            pre_q   <= '0;
            us_q    <= '0;
          end
        end
        StSlotRel: begin
          // 15 us after slot start.
          if (op_q == OpRead && us_q == 9'd9 && pre_q == '0) rd_q[bit_q] <= w_sync;
          if (phase_end) begin
            pre_q <= '0;
            us_q  <= '0;
            if (bit_q == 3'd7) begin
              state_q     <= StDone;
              rsp_valid_q <= 1'b1;
              if (op_q == OpRead) rsp_data_q <= rd_q;
            end else begin
              bit_q   <= bit_q + 3'd1;
              state_q <= StSlotLow;
              w_out_q <= 1'b0;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          w_out_q <= 1'b1;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign CMD_READY    = ready_q;
  assign BUSY         = ~ready_q;
  assign W_OUT        = w_out_q;
  assign RSP_VALID    = rsp_valid_q;
  assign RSP_DATA     = rsp_data_q;
  assign RSP_PRESENCE = rsp_pres_q;

endmodule

// File: tb/tb_onewire_master.sv
// tb_onewire_master: self-checking bench for onewire_master with a behavioural bus device.
// Timing below: "latency" is the count of edges from the accept edge to the first edge at
// which RSP_VALID is sampled high.
module tb_onewire_master;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid, cmd_ready, rsp_valid, rsp_presence, busy, w_out, w_in;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data, rsp_data;

  always #5 clk = ~clk;

  onewire_master #(.CLK_PER_US(C)) dut (
    .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op),
    .CMD_DATA(cmd_data), .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data),
    .RSP_PRESENCE(rsp_presence), .BUSY(busy), .W_OUT(w_out), .W_IN(w_in)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus device: presence pulse after a long reset low, read responder pulling 0-bits low.
  bit         dev_present = 1'b0;
  bit         dev_read = 1'b0;
  logic [7:0] dev_byte = 8'h00;
  int         dev_idx = 0;
  int         pull_from = 0, pull_until = 0;
  logic       dev_pull = 1'b0;
  logic       w_prev = 1'b1;
  int         fall_cyc = 0, rise_cyc = 0;
  int         widths[$];
  int         rv_count = 0;

  assign w_in = w_out & ~dev_pull;

  always @(negedge clk) begin
    if (w_prev === 1'b1 && w_out === 1'b0) begin
      fall_cyc = cyc;
      if (dev_read) begin
        if (!dev_byte[dev_idx[2:0]]) begin
          pull_from  = cyc;
          pull_until = cyc + 30 * C;
        end
        dev_idx++;
      end
    end
    if (w_prev === 1'b0 && w_out === 1'b1) begin
      rise_cyc = cyc;
      widths.push_back(cyc - fall_cyc);
      if (dev_present && (cyc - fall_cyc) >= 400 * C) begin
        pull_from  = cyc + 30 * C;
        pull_until = cyc + 150 * C;
      end
    end
    dev_pull = (cyc >= pull_from) && (cyc < pull_until);
    w_prev = w_out;
    if (rsp_valid === 1'b1) rv_count++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] op);
    case (op)
      2'b00:        return 960 * C + 1;
      2'b01, 2'b10: return 560 * C + 1;
      default:      return 1;
    endcase
  endfunction

  function automatic int exp_pulses(input logic [1:0] op);
    case (op)
      2'b00:        return 1;
      2'b01, 2'b10: return 8;
      default:      return 0;
    endcase
  endfunction

  // Low time in us of pulse i: reset 480, written 0 is 60, written 1 and read slots 6.
  function automatic int exp_low_us(input logic [1:0] op, input logic [7:0] d, input int i);
    if (op == 2'b00) return 480;
    if (op == 2'b01 && !d[i]) return 60;
    return 6;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("%s ready", tag), {31'd0, cmd_ready}, 1);
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [7:0] data,
                       input bit present, input logic [7:0] rbyte,
                       input logic [7:0] exp_data, input logic exp_pres);
    int acc;
    int n;
    int np;
    dev_present = present;
    dev_read = (op == 2'b10);
    dev_byte = rbyte;
    dev_idx = 0;
    wait_ready(tag);
    @(negedge clk);
    widths.delete();
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
    if (op != 2'b11) begin
      check($sformatf("%s busy", tag), {31'd0, busy}, 1);
      check($sformatf("%s drive", tag), {31'd0, w_out}, 0);
    end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("%s latency", tag), cyc + 1 - acc, exp_lat(op));
    np = exp_pulses(op);
    check($sformatf("%s pulses", tag), widths.size(), np);
    for (int i = 0; i < np && i < widths.size(); i++)
      check($sformatf("%s width%0d", tag, i), widths[i], exp_low_us(op, data, i) * C);
    if (op == 2'b00) check($sformatf("%s release", tag), cyc - rise_cyc, 480 * C);
    check($sformatf("%s data", tag), {24'd0, rsp_data}, {24'd0, exp_data});
    check($sformatf("%s presence", tag), {31'd0, rsp_presence}, {31'd0, exp_pres});
    @(posedge clk); #1;
    check($sformatf("%s one-shot", tag), {31'd0, rsp_valid}, 0);
    check($sformatf("%s ready back", tag), {31'd0, cmd_ready}, 1);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    bit         present;
    logic [7:0] rbyte;
    logic [7:0] exp_data;
    logic       exp_pres;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] m_data;
  logic       m_pres;
  int         rv0, n, a0, a1, a2, r;
  bit         seen_rdy;

  initial begin
    vecs[0] = '{2'b00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[1] = '{2'b00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{2'b00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[3] = '{2'b01, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{2'b10, 8'h00, 1'b0, 8'h3C, 8'h3C, 1'b1};
    vecs[5] = '{2'b11, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b1};
    vecs[6] = '{2'b01, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b1};
    vecs[7] = '{2'b11, 8'hFF, 1'b1, 8'h00, 8'h3C, 1'b1};
    vecs[8] = '{2'b10, 8'h00, 1'b0, 8'hC3, 8'hC3, 1'b1};

    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset w_out", {31'd0, w_out}, 1);
    check("reset ready", {31'd0, cmd_ready}, 1);
    check("reset busy", {31'd0, busy}, 0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 0);
    check("reset rsp_data", {24'd0, rsp_data}, 0);
    check("reset presence", {31'd0, rsp_presence}, 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 9; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].present, vecs[i].rbyte,
            vecs[i].exp_data, vecs[i].exp_pres);

    // Abort a write while bit 3 (a 0, long low) is driving the line.
    dev_read = 1'b0; dev_present = 1'b0;
    wait_ready("abort");
    @(negedge clk);
    widths.delete();
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 8'hA5;
    @(posedge clk); #1 cmd_valid = 1'b0;
    rv0 = rv_count;
    n = 0;
    while (!(widths.size() == 3 && w_out === 1'b0) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    check("abort bit3 low", {31'd0, w_out}, 0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("abort async release", {31'd0, w_out}, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    check("abort no rsp", rv_count - rv0, 0);
    check("abort ready", {31'd0, cmd_ready}, 1);
    check("abort rsp_data cleared", {24'd0, rsp_data}, 0);
    check("abort presence cleared", {31'd0, rsp_presence}, 0);
    check("abort line idle", {31'd0, w_out}, 1);
    do_op("post-abort read", 2'b10, 8'h00, 1'b0, 8'h5A, 8'h5A, 1'b0);
    m_data = 8'h5A; m_pres = 1'b0;

    // Back-to-back with CMD_VALID held: no-op, write 00, no-op.
    dev_read = 1'b0; dev_present = 1'b0;
    wait_ready("hs");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 8'h00;
    @(posedge clk); #1;
    a0 = cyc;
    check("hs noop rsp", {31'd0, rsp_valid}, 1);
    cmd_op = 2'b01;
    n = 0; seen_rdy = 1'b0; a1 = -1;
    while (a1 < 0 && n < 20) begin
      @(posedge clk); #1; n++;
      if (seen_rdy && busy === 1'b1) a1 = cyc;
      if (cmd_ready === 1'b1) seen_rdy = 1'b1;
    end
    check("hs write accept", a1 - a0, 2);
    cmd_op = 2'b11;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    r = cyc;
    check("hs write latency", r + 1 - a1, 560 * C + 1);
    n = 0; a2 = -1;
    while (a2 < 0 && n < 10) begin
      @(posedge clk); #1; n++;
      if (rsp_valid === 1'b1) a2 = cyc;
    end
    check("hs noop2 accept", a2 - r, 2);
    cmd_valid = 1'b0;
    check("hs data kept", {24'd0, rsp_data}, {24'd0, m_data});
    check("hs presence kept", {31'd0, rsp_presence}, {31'd0, m_pres});

    // A read pulsed while a write runs must be dropped.
    wait_ready("drop");
    @(negedge clk);
    widths.delete();
    rv0 = rv_count;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 8'hFF;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk) begin cmd_valid = 1'b1; cmd_op = 2'b10; end
    @(negedge clk) cmd_valid = 1'b0;
    repeat (2800) @(posedge clk);
    #1;
    check("drop rsp count", rv_count - rv0, 1);
    check("drop pulses", widths.size(), 8);
    check("drop data kept", {24'd0, rsp_data}, {24'd0, m_data});

    // Random commands against the reference model.
    for (int i = 0; i < 8; i++) begin
      logic [1:0] op;
      logic [7:0] d, rb;
      bit         p;
      op = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      rb = 8'($urandom);
      p  = 1'($urandom_range(0, 1));
      if (op == 2'b00) m_pres = p;
      if (op == 2'b10) m_data = rb;
      do_op($sformatf("rnd%0d", i), op, d, p, rb, m_data, m_pres);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
